// File: rtl/noc_link_rx_endpoint.sv
// Credit-based router link receiver presented as an AXI-Stream master, with a small FWFT flit FIFO.
// Optional statistics counters are built when NOC_LINK_RX_STATS_EN is defined.
//
// Framing FSM states:
//   state  | meaning
//   IDLE   | between packets; next flit is a head, its dest is latched
//   IN_PKT | inside a multi-flit packet; dest must match the latched head dest
module noc_link_rx_endpoint #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  axis_out_tvalid,
  input  logic                  axis_out_tready,
  output logic [FLIT_WIDTH-1:0] axis_out_tdata,
  output logic [DEST_WIDTH-1:0] axis_out_tdest,
  output logic                  axis_out_tlast,
  output logic [CNT_WIDTH-1:0]  fill_level,
  output logic                  overflow_err,
  output logic                  framing_err,
`ifdef NOC_LINK_RX_STATS_EN
  output logic [31:0]           stat_flits,
  output logic [31:0]           stat_pkts,
`endif
  input  logic                  err_clear
);

  localparam int PTR_WIDTH   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int ENTRY_WIDTH = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  logic [ENTRY_WIDTH-1:0] mem [FLIT_BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic                   full;
  logic                   push;
  logic                   pop;
  state_t                 state;
  logic [DEST_WIDTH-1:0]  pkt_dest;

  assign full            = (fill_level == FULL_LEVEL);
  assign axis_out_tvalid = (fill_level != '0);
  assign pop             = axis_out_tvalid & axis_out_tready;
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign push            = send_in & (~full | pop);

  assign {axis_out_tdata, axis_out_tdest, axis_out_tlast} = mem[rd_ptr];

  always_ff @(posedge clk_noc) begin
    if (push) mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      credit_out <= pop;
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + CNT_WIDTH'(1);
        2'b01:   fill_level <= fill_level - CNT_WIDTH'(1);
        default: fill_level <= fill_level;
      endcase
      if (send_in & ~push)  overflow_err <= 1'b1;
      else if (err_clear)   overflow_err <= 1'b0;
    end
  end

  // Framing follows every arriving flit, including ones dropped on overflow.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state       <= IDLE;
      pkt_dest    <= '0;
      framing_err <= 1'b0;
    end else begin
      if (send_in) begin
        case (state)
          IDLE: begin
            pkt_dest <= dest_in;
            state    <= is_tail_in ? IDLE : IN_PKT;
          end
          IN_PKT: begin
            if (is_tail_in) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (send_in && state == IN_PKT && dest_in != pkt_dest) framing_err <= 1'b1;
      else if (err_clear)                                     framing_err <= 1'b0;
    end
  end

`ifdef NOC_LINK_RX_STATS_EN
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      stat_flits <= '0;
      stat_pkts  <= '0;
    end else begin
      if (pop)                  stat_flits <= stat_flits + 32'd1;
      if (pop & axis_out_tlast) stat_pkts  <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_link_rx_endpoint.sv
// Directed vector table plus backpressure and mid-packet reset sequences for noc_link_rx_endpoint.
// Stats counters are checked when NOC_LINK_RX_STATS_EN is defined.
module tb_noc_link_rx_endpoint;

  logic        clk_noc = 1'b0;
  logic        rst_noc;
  logic [31:0] data_in;
  logic [3:0]  dest_in;
  logic        is_tail_in;
  logic        send_in;
  logic        credit_out;
  logic        axis_out_tvalid;
  logic        axis_out_tready;
  logic [31:0] axis_out_tdata;
  logic [3:0]  axis_out_tdest;
  logic        axis_out_tlast;
  logic [1:0]  fill_level;
  logic        overflow_err;
  logic        framing_err;
  logic        err_clear;
`ifdef NOC_LINK_RX_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_pkts;
`endif

  int checks = 0;
  int errors = 0;

  noc_link_rx_endpoint #(
    .FLIT_WIDTH(32), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(2)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tdest(axis_out_tdest),
    .axis_out_tlast(axis_out_tlast),
    .fill_level(fill_level), .overflow_err(overflow_err), .framing_err(framing_err),
`ifdef NOC_LINK_RX_STATS_EN
    .stat_flits(stat_flits), .stat_pkts(stat_pkts),
`endif
    .err_clear(err_clear)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    logic        send;
    logic [31:0] data;
    logic [3:0]  dest;
    logic        tail;
    logic        tready;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    int          e_fill;
    logic        e_credit;
    logic        e_ovf;
    logic        e_frm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic [31:0] d, input logic [3:0] ds,
                              input logic t, input logic r, input logic c,
                              input logic ev, input logic [31:0] ed, input logic el,
                              input int ef, input logic ecr, input logic eo, input logic efr);
    vec_t v;
    v.send = s; v.data = d; v.dest = ds; v.tail = t; v.tready = r; v.clr = c;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_fill = ef;
    v.e_credit = ecr; v.e_ovf = eo; v.e_frm = efr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_noc);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] d, input logic [3:0] ds, input logic t);
    send_in = s; data_in = d; dest_in = ds; is_tail_in = t;
  endtask

  logic [36:0] exp_q[$];
  logic [36:0] held_val;
  logic        held;
  int          credits, credit_cnt, total_flits, pkts_sent, flits_in_pkt, pkt_len, stab_err;
  logic [3:0]  pkt_dest;
  logic [31:0] rnd_data;
  logic        tail;
  logic        done;

  initial begin
    rst_noc = 1'b1; err_clear = 1'b0; axis_out_tready = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    chk("reset tvalid", axis_out_tvalid, 0);
    chk("reset fill", fill_level, 0);
    chk("reset credit", credit_out, 0);
    chk("reset ovf", overflow_err, 0);
    chk("reset frm", framing_err, 0);
    repeat (2) @(posedge clk_noc);
    #1 rst_noc = 1'b0;
    tick;

    // stream
    vecs.push_back(mk(1, 'h10, 5, 0, 1, 0,  1, 'h10, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'h11, 5, 0, 1, 0,  1, 'h11, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 'h12, 5, 0, 1, 0,  1, 'h12, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 'h13, 5, 1, 1, 0,  1, 'h13, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 0, 0, 0));
    // full and overflow
    vecs.push_back(mk(1, 'hA0, 1, 0, 0, 0,  1, 'hA0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'hA1, 1, 1, 0, 0,  1, 'hA0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 'hA2, 2, 1, 0, 0,  1, 'hA0, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  1, 'hA1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 1,  0, 0,    0, 0, 0, 0, 0));
    // push and pop together while full
    vecs.push_back(mk(1, 'hB0, 3, 1, 0, 0,  1, 'hB0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'hB1, 3, 1, 0, 0,  1, 'hB0, 1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 'hB2, 3, 1, 1, 0,  1, 'hB1, 1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  1, 'hB2, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 0, 0, 0));
    // framing
    vecs.push_back(mk(1, 'hC0, 3, 0, 1, 0,  1, 'hC0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'hC1, 3, 0, 1, 0,  1, 'hC1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 'hC2, 7, 1, 1, 0,  1, 'hC2, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0,    0, 0, 1, 1,  0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 'hD0, 2, 1, 1, 0,  1, 'hD0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 'hE0, 9, 1, 1, 0,  1, 'hE0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 1, 0,  0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 'hF0, 1, 0, 1, 0,  1, 'hF0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'hF1, 4, 1, 1, 1,  1, 'hF1, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0,    0, 0, 1, 1,  0, 0,    0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].send, vecs[i].data, vecs[i].dest, vecs[i].tail);
      axis_out_tready = vecs[i].tready;
      err_clear = vecs[i].clr;
      tick;
      chk($sformatf("v%0d tvalid", i), axis_out_tvalid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d tdata", i), axis_out_tdata, vecs[i].e_data);
        chk($sformatf("v%0d tlast", i), axis_out_tlast, vecs[i].e_last);
      end
      chk($sformatf("v%0d fill", i), fill_level, vecs[i].e_fill);
      chk($sformatf("v%0d credit", i), credit_out, vecs[i].e_credit);
      chk($sformatf("v%0d ovf", i), overflow_err, vecs[i].e_ovf);
      chk($sformatf("v%0d frm", i), framing_err, vecs[i].e_frm);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    err_clear = 1'b0;
    tick;

    // randomized backpressure with an upstream credit model
    credits = 2; credit_cnt = 0; total_flits = 0; pkts_sent = 0; flits_in_pkt = 0;
    pkt_len = 1; pkt_dest = 4'h0; stab_err = 0; held = 1'b0; held_val = '0; done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (credit_out) begin
        credits++;
        credit_cnt++;
      end
      if (held && (!axis_out_tvalid || {axis_out_tdest, axis_out_tlast, axis_out_tdata} != held_val))
        stab_err++;
      axis_out_tready = 1'($urandom_range(0, 1));
      if (axis_out_tvalid && axis_out_tready) begin
        if (exp_q.size() == 0) chk("bp underrun", 1, 0);
        else chk("bp flit", {axis_out_tdest, axis_out_tlast, axis_out_tdata}, exp_q.pop_front());
      end
      held = axis_out_tvalid && !axis_out_tready;
      held_val = {axis_out_tdest, axis_out_tlast, axis_out_tdata};
      if (credits > 0 && pkts_sent < 100 && $urandom_range(0, 3) != 0) begin
        if (flits_in_pkt == 0) begin
          pkt_len = int'($urandom_range(1, 4));
          pkt_dest = 4'($urandom);
        end
        rnd_data = $urandom;
        tail = (flits_in_pkt == pkt_len - 1);
        drive(1'b1, rnd_data, pkt_dest, tail);
        exp_q.push_back({pkt_dest, tail, rnd_data});
        credits--;
        total_flits++;
        flits_in_pkt++;
        if (tail) begin
          flits_in_pkt = 0;
          pkts_sent++;
        end
      end else begin
        drive(1'b0, 32'h0, 4'h0, 1'b0);
      end
      tick;
      done = (pkts_sent == 100) && (exp_q.size() == 0) && (credits + (credit_out ? 1 : 0) == 2);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    axis_out_tready = 1'b0;
    if (credit_out) credit_cnt++;
    chk("bp timeout", done, 1);
    chk("bp credits", credit_cnt, total_flits);
    chk("bp stable", stab_err, 0);
    chk("bp ovf", overflow_err, 0);
    chk("bp frm", framing_err, 0);
    tick;

    // reset in the middle of a packet
    drive(1'b1, 32'h60, 4'h6, 1'b0);
    tick;
    drive(1'b1, 32'h61, 4'h6, 1'b0);
    tick;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    chk("mid fill pre", fill_level, 2);
    #2 rst_noc = 1'b1;
    #1;
    chk("mid tvalid", axis_out_tvalid, 0);
    chk("mid fill", fill_level, 0);
    tick;
    chk("mid credit", credit_out, 0);
    rst_noc = 1'b0;
`ifdef NOC_LINK_RX_STATS_EN
    chk("stat flits rst", stat_flits, 0);
    chk("stat pkts rst", stat_pkts, 0);
`endif
    axis_out_tready = 1'b1;
    drive(1'b1, 32'h80, 4'h8, 1'b0);
    tick;
    chk("post h0", axis_out_tdata, 32'h80);
    drive(1'b1, 32'h81, 4'h8, 1'b0);
    tick;
    chk("post h1", axis_out_tdata, 32'h81);
    chk("post credit", credit_out, 1);
    drive(1'b1, 32'h82, 4'h8, 1'b1);
    tick;
    chk("post h2", axis_out_tdata, 32'h82);
    chk("post tlast", axis_out_tlast, 1);
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick;
    chk("post tvalid", axis_out_tvalid, 0);
    chk("post frm", framing_err, 0);
    tick;
`ifdef NOC_LINK_RX_STATS_EN
    chk("stat flits", stat_flits, 3);
    chk("stat pkts", stat_pkts, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
